// File: rtl/fetch_pkg.sv
// Fetch sequencer shared types, widths and redirect target math.
// Imported by fetch_buf and fetch_sequencer.
package fetch_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_RSP = 2'd2,
    DRAIN    = 2'd3
  } fetch_state_t;

  // Jump wins over branch; both are relative to the resolving PC + 2.
  function automatic logic [ADDR_W-1:0] fetch_target(
    input logic              jmp,
    input logic [ADDR_W-1:0] redir_pc,
    input logic [ADDR_W-1:0] br_off,
    input logic [ADDR_W-1:0] jmp_instr
  );
    logic [ADDR_W-1:0] seq;
    seq = redir_pc + ADDR_W'(2);
    if (jmp)
      return {seq[15:12], jmp_instr[10:0], 1'b0};
    return seq + br_off;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: small synchronous FIFO with flush.
// Push while full succeeds only when a pop happens in the same cycle.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; flush empties in one cycle.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, buffered.
// Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [ADDR_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_off,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_instr,
  input  logic [ADDR_W-1:0] redir_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       redir_cnt
`endif
);

  fetch_state_t      state, state_d;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_d;
  logic [ADDR_W-1:0] lat_pc, lat_pc_d;
  logic [ADDR_W-1:0] target;
  logic              redir;
  logic              req_fire;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_empty;
  logic              buf_full;
  logic [2*ADDR_W-1:0] buf_head;

  assign redir    = br_taken | jmp;
  assign target   = fetch_target(jmp, redir_pc, br_off, jmp_instr);
  assign req_fire = imem_req_valid & imem_req_ready;

  assign imem_req_valid = (state == RUN) && !buf_full;
  assign imem_req_addr  = imem_req_valid ? fetch_pc : '0;

  assign instr_valid = !buf_empty;
  assign instr_data  = instr_valid ? buf_head[2*ADDR_W-1:ADDR_W] : '0;
  assign instr_pc    = instr_valid ? buf_head[ADDR_W-1:0] : '0;

  // A redirect squashes both the incoming response and any pop.
  assign buf_push = (state == WAIT_RSP) && imem_rsp_valid && !redir;
  assign buf_pop  = instr_valid && instr_ready && !redir;

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (2 * ADDR_W)
  ) u_buf (
    .clock (clock),
    .reset (reset),
    .flush (redir),
    .push  (buf_push),
    .wdata ({imem_rsp_data, lat_pc}),
    .pop   (buf_pop),
    .rdata (buf_head),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // State, fetch PC and issued-address registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      lat_pc   <= '0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      lat_pc   <= lat_pc_d;
    end
  end

  // Next-state and fetch PC selection.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    lat_pc_d   = lat_pc;
    unique case (state)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (redir) begin
          fetch_pc_d = target;
          if (req_fire) state_d = DRAIN;
        end else if (req_fire) begin
          fetch_pc_d = fetch_pc + ADDR_W'(2);
          lat_pc_d   = fetch_pc;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (redir) begin
          fetch_pc_d = target;
          state_d    = imem_rsp_valid ? RUN : DRAIN;
        end else if (imem_rsp_valid) begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (redir) fetch_pc_d = target;
        if (imem_rsp_valid) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;

  assign stall = ((state == RUN) && buf_full) ||
                 (state == WAIT_RSP) || (state == DRAIN);

  // Saturating stall and redirect counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 1'b1;
      if (redir && (state != IDLE) && (redir_cnt != 16'hFFFF))
        redir_cnt <= redir_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a latency-programmable
// instruction memory model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        br_taken;
  logic [15:0] br_off;
  logic        jmp;
  logic [15:0] jmp_instr;
  logic [15:0] redir_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] redir_cnt;
`endif

  int          n_chk;
  int          n_pass;
  int          n_redir;
  int          lat;
  int          m_cnt;
  logic [15:0] m_addr;
  logic [15:0] model_pc;
  logic [15:0] q[$];
  logic [15:0] iss[$];
  int          mark;

  fetch_sequencer #(
    .RESET_PC  (16'h0100),
    .BUF_DEPTH (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .br_taken       (br_taken),
    .br_off         (br_off),
    .jmp            (jmp),
    .jmp_instr      (jmp_instr),
    .redir_pc       (redir_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .redir_cnt      (redir_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] tb_target();
    logic [15:0] s;
    s = redir_pc + 16'd2;
    if (jmp) return {s[15:12], jmp_instr[10:0], 1'b0};
    return s + br_off;
  endfunction

  function automatic logic [31:0] iss_at(input int i);
    if (iss.size() > i) return {16'h0, iss[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  // Monitor, reference model and memory responder.
  initial begin
    logic        rd;
    logic [15:0] e;
    forever begin
      @(negedge clock);
      rd = br_taken | jmp;
      if (reset) begin
        q.delete();
        model_pc = 16'h0100;
        m_cnt    = 0;
      end else begin
        if (instr_valid && instr_ready && !rd) begin
          if (q.size() == 0) begin
            chk("sb_underflow", {16'h0, instr_pc}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("instr_pc", {16'h0, instr_pc}, {16'h0, e});
            chk("instr_data", {16'h0, instr_data},
                {16'h0, mem_word(e)});
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", {16'h0, imem_req_addr}, {16'h0, model_pc});
          iss.push_back(imem_req_addr);
          m_cnt  = lat;
          m_addr = imem_req_addr;
          if (!rd) begin
            q.push_back(imem_req_addr);
            model_pc = model_pc + 16'd2;
          end
        end
        if (rd) begin
          model_pc = tb_target();
          q.delete();
          n_redir++;
        end
      end
      @(posedge clock);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(m_addr);
        end
      end
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; n_redir = 0;
    lat = 1; m_cnt = 0; m_addr = '0; model_pc = 16'h0100;
    reset = 1'b1;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    br_taken = 1'b0; br_off = '0; jmp = 1'b0;
    jmp_instr = '0; redir_pc = '0;

    repeat (3) cyc();
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", {16'h0, imem_req_addr}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr_data", {16'h0, instr_data}, 32'h0);
    chk("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));

    // Reset release, always-ready memory, 1-cycle response.
    reset = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    cyc();
    chk("run_state", 32'(dut.state), 32'(RUN));
    repeat (12) cyc();
    chk("first_addr0", iss_at(0), 32'h0100);
    chk("first_addr1", iss_at(1), 32'h0102);
    chk("first_addr2", iss_at(2), 32'h0104);

    // Decode stall: buffer fills, requests stop, nothing lost.
    instr_ready = 1'b0;
    repeat (8) cyc();
    chk("full_no_req", {31'h0, imem_req_valid}, 32'h0);
    chk("full_valid", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b1;
    repeat (6) cyc();

    // Jump and branch together while buffer is full.
    instr_ready = 1'b0;
    repeat (8) cyc();
    jmp = 1'b1; br_taken = 1'b1; br_off = 16'h0010;
    redir_pc = 16'h3FFE; jmp_instr = 16'h2123;
    cyc();
    jmp = 1'b0; br_taken = 1'b0;
    chk("flush_valid", {31'h0, instr_valid}, 32'h0);
    mark = iss.size();
    instr_ready = 1'b1;
    repeat (8) cyc();
    chk("jmp_target", iss_at(mark), 32'h4246);

    // Jump to the top of memory, then wrap.
    jmp = 1'b1; redir_pc = 16'hF000; jmp_instr = 16'h07FF;
    cyc();
    jmp = 1'b0;
    mark = iss.size();
    repeat (10) cyc();
    chk("wrap_top", iss_at(mark), 32'hFFFE);
    chk("wrap_zero", iss_at(mark + 1), 32'h0000);

    // Branch while waiting on a 2-cycle response.
    lat = 2; imem_req_ready = 1'b0;
    repeat (6) cyc();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    chk("wait_state", 32'(dut.state), 32'(WAIT_RSP));
    br_taken = 1'b1; redir_pc = 16'h0040; br_off = 16'hFFF8;
    cyc();
    br_taken = 1'b0;
    chk("drain_state", 32'(dut.state), 32'(DRAIN));
    mark = iss.size();
    imem_req_ready = 1'b1;
    repeat (8) cyc();
    chk("br_target", iss_at(mark), 32'h003A);

    // Reset while a response is arriving.
    lat = 1; imem_req_ready = 1'b0;
    repeat (6) cyc();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_mid_req", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
    mark = iss.size();
    imem_req_ready = 1'b1;
    repeat (6) cyc();
    chk("rst_mid_pc", iss_at(mark), 32'h0100);

    // Quiesce and confirm every issued fetch was delivered.
    imem_req_ready = 1'b0;
    repeat (6) cyc();
    chk("sb_left", 32'(q.size()), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("redir_cnt", {16'h0, redir_cnt}, 32'(n_redir));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the number of instruction buffer entries (legal range 2..8).
REQ-003 SHALL have port clock  in  1  single processor clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports imem_req_valid out 1 / imem_req_ready in 1 / imem_req_addr out 16  for the instruction-memory request handshake.
REQ-006 SHALL have ports imem_rsp_valid in 1 / imem_rsp_data in 16  for the instruction-memory response (no backpressure).
REQ-007 SHALL have ports instr_valid out 1 / instr_ready in 1 / instr_data out 16 / instr_pc out 16  for the decode handshake.
REQ-008 SHALL have ports br_taken in 1 (branch flag AND ALU zero), br_off in 16 signed (sign-extended offset, already <<1), jmp in 1, jmp_instr in 16, and redir_pc in 16 (PC of the resolving instruction).

Function
REQ-009 SHALL run the state machine IDLE, RUN, WAIT_RSP and DRAIN, with IDLE->RUN on the first cycle out of reset.
REQ-010 SHALL hold the next fetch address in fetch_pc and, in RUN, assert imem_req_valid with imem_req_addr=fetch_pc whenever buffer occupancy < BUF_DEPTH.
REQ-011 SHALL keep imem_req_valid and imem_req_addr stable until imem_req_ready, except that a redirect withdraws or retargets the request.
REQ-012 On a request handshake, SHALL set fetch_pc <= fetch_pc+2 (mod 2^16; 16'hFFFE wraps to 16'h0000), latch the issued address, and move RUN->WAIT_RSP; at most one request is outstanding.
REQ-013 In WAIT_RSP with imem_rsp_valid, SHALL push {imem_rsp_data, latched address} into the buffer and return to RUN; instr_valid rises the following cycle.
REQ-014 SHALL present the buffer head on instr_data/instr_pc with instr_valid=1 when the buffer is non-empty, and pop on instr_valid&&instr_ready.
REQ-015 On a redirect (br_taken|jmp), SHALL compute the target as jmp ? {(redir_pc+2)[15:12], jmp_instr[10:0], 1'b0} : redir_pc+2+br_off (16-bit wrap); jmp wins when both are set.
REQ-016 On a redirect, SHALL flush the buffer (instr_valid=0 next cycle) and set fetch_pc=target, with flush taking priority over a same-cycle pop.
REQ-017 A redirect with a request outstanding, or coinciding with a request handshake, SHALL enter DRAIN; DRAIN discards the next imem_rsp_valid and then goes to RUN.
REQ-018 A redirect in WAIT_RSP in the same cycle as imem_rsp_valid SHALL discard that response and go directly to RUN.
REQ-019 A redirect in DRAIN SHALL update fetch_pc only and remain in DRAIN.
REQ-020 A push and a pop in the same cycle with the buffer full SHALL both succeed, with occupancy unchanged.

Reset
REQ-021 With reset high at a clock edge, SHALL set state=IDLE, fetch_pc=RESET_PC, buffer empty, imem_req_valid=0, instr_valid=0, and imem_req_addr/instr_data/instr_pc=16'h0000.
REQ-022 Reset mid-operation SHALL abandon any outstanding request and ignore imem_rsp_valid while reset is high; the memory shares this reset.

Configuration
REQ-023 When FETCH_PERF_CNT_EN is defined, SHALL add outputs stall_cnt out 16 (cycles in RUN with the buffer full or in WAIT_RSP/DRAIN) and redir_cnt out 16 (redirects), both saturating at 16'hFFFF and reset to 0.
REQ-024 When FETCH_PERF_CNT_EN is undefined, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-025 SHALL place the state enum fetch_state_t, the width constant ADDR_W=16 and the target-computation function in package fetch_pkg.
REQ-026 SHALL implement the buffer as sub-module fetch_buf, a BUF_DEPTH-entry 32-bit synchronous FIFO with a flush input.

Verification
REQ-027 Reset release with RESET_PC=16'h0100 and memory always ready with 1-cycle response -> addresses 0100, 0102, 0104 issued and instr_pc follows in order.
REQ-028 Decode holds instr_ready=0 -> after 2 pushes imem_req_valid=0 until the first pop, and no entry is lost.
REQ-029 br_taken with redir_pc=16'h0040 and br_off=16'hFFF8 while WAIT_RSP -> state DRAIN, stale response dropped, next request at 16'h003A.
REQ-030 jmp with redir_pc=16'h3FFE and jmp_instr=16'h2123 in the same cycle as br_taken -> next request at 16'h4246 (jump priority).
REQ-031 fetch_pc=16'hFFFE handshake -> next request at 16'h0000.
REQ-032 reset asserted while WAIT_RSP with a response in the same cycle -> response ignored, instr_valid=0, first post-reset request at RESET_PC.
